// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Central pipeline controller for the 5-stage MIPS core.
//               - Merges per-stage stall requests into stall[5:0]
//                 (bit0=pc, 1=if/id, 2=id/ex, 3=ex/mem, 4=mem/wb, 5=wb).
//               - Sequences exception/ERET flushes (flush + new_pc).
//               - Watchdog flags stalls held for TIMEOUT consecutive cycles.
// Ports       : clk, rst (sync, active-high)
//               stallreq_if/id/ex/mem  per-stage stall requests
//               excepttype[31:0]       exception code, 0 = none
//               cp0_epc[31:0]          ERET return address
//               stall[5:0]             stall vector (combinational)
//               flush                  flush all pipeline registers
//               new_pc[31:0]           redirect target while flush=1, else 0
//               stall_timeout          sticky watchdog flag
// Config      : PIPE_PERF_EN adds stall_cycles[31:0] / flush_events[31:0].
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
  parameter int unsigned FLUSH_LEN  = 1,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam int unsigned     WD_W         = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] C_WD_MAX     = WD_W'(TIMEOUT);
  localparam logic [3:0]      C_FLUSH_INIT = 4'(FLUSH_LEN - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_flush_cnt;
  logic [3:0]        w_flush_cnt_next;
  logic [31:0]       r_new_pc_q;
  logic [31:0]       w_new_pc_q_next;
  logic              w_exc;
  logic [31:0]       w_target;
  logic [5:0]        w_stall_req;
  logic [WD_W-1:0]   r_wd_cnt;
  logic [WD_W-1:0]   w_wd_next;
  logic              r_timeout;

  assign w_exc    = (excepttype != 32'd0);
  assign w_target = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;

  // Deepest requester wins: a stalled stage also freezes everything upstream.
  always_comb begin
    w_stall_req = 6'b000000;
    if (stallreq_mem)      w_stall_req = 6'b011111;
    else if (stallreq_ex)  w_stall_req = 6'b001111;
    else if (stallreq_id)  w_stall_req = 6'b000111;
    else if (stallreq_if)  w_stall_req = 6'b000011;
  end

  // Flush sequencer: next-state and outputs.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_new_pc_q_next  = r_new_pc_q;
    flush            = 1'b0;
    new_pc           = 32'd0;
    case (r_state)
      RUN: begin
        if (w_exc) begin
          flush           = 1'b1;
          new_pc          = w_target;
          w_new_pc_q_next = w_target;
          if (FLUSH_LEN > 1) begin
            w_state_next     = FLUSH;
            w_flush_cnt_next = C_FLUSH_INIT;
          end
        end
      end
      FLUSH: begin
        // excepttype is deliberately ignored until the flush completes.
        flush            = 1'b1;
        new_pc           = r_new_pc_q;
        w_flush_cnt_next = r_flush_cnt - 4'd1;
        if (r_flush_cnt <= 4'd1) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // A flushing pipeline must not hold any stage.
  assign stall = flush ? 6'b000000 : w_stall_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_flush_cnt <= 4'd0;
      r_new_pc_q  <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_new_pc_q  <= w_new_pc_q_next;
    end
  end

  // Watchdog: counts consecutive stalled cycles, saturating at TIMEOUT.
  always_comb begin
    if (flush || (stall == 6'b000000)) begin
      w_wd_next = '0;
    end else if (r_wd_cnt == C_WD_MAX) begin
      w_wd_next = r_wd_cnt;
    end else begin
      w_wd_next = r_wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_next;
      r_timeout <= r_timeout | (w_wd_next == C_WD_MAX);
    end
  end

  assign stall_timeout = r_timeout;

`ifdef PIPE_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (stall != 6'b000000) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      // Only a fresh entry counts; cycles spent inside FLUSH do not.
      if ((r_state == RUN) && w_exc) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Three instances share the
//               same stimulus with FLUSH_LEN = 1, 3, 4 and TIMEOUT = 8; a
//               behavioural model predicts every output each cycle, and a
//               few directed sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int N = 3;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic [31:0] excepttype = 32'd0;
  logic [31:0] cp0_epc = 32'd0;

  logic [5:0]  stall_v   [N];
  logic        flush_v   [N];
  logic [31:0] new_pc_v  [N];
  logic        tmo_v     [N];
`ifdef PIPE_PERF_EN
  logic [31:0] scyc_v    [N];
  logic [31:0] fev_v     [N];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipe_ctrl #(
      .EXC_VECTOR(32'h0000_0020),
      .ERET_CODE (32'h0000_000e),
      .FLUSH_LEN ((g == 0) ? 1 : (g == 1) ? 3 : 4),
      .TIMEOUT   (TMO)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_if  (stallreq_if),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excepttype   (excepttype),
      .cp0_epc      (cp0_epc),
      .stall        (stall_v[g]),
      .flush        (flush_v[g]),
      .new_pc       (new_pc_v[g]),
      .stall_timeout(tmo_v[g])
`ifdef PIPE_PERF_EN
      ,
      .stall_cycles (scyc_v[g]),
      .flush_events (fev_v[g])
`endif
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rem: flush cycles still owed after the current one; tgt: held target;
  // run: consecutive stalled cycles; to: sticky watchdog.
  int          flen [N] = '{1, 3, 4};
  int          rem  [N] = '{0, 0, 0};
  logic [31:0] tgt  [N] = '{0, 0, 0};
  int          run  [N] = '{0, 0, 0};
  bit          to   [N] = '{0, 0, 0};
  int unsigned m_scyc [N] = '{0, 0, 0};
  int unsigned m_fev  [N] = '{0, 0, 0};

  function automatic logic [5:0] req_vec(bit f, bit i, bit d, bit e, bit m);
    if (f)      return 6'd0;
    if (m)      return 6'b011111;
    if (e)      return 6'b001111;
    if (d)      return 6'b000111;
    if (i)      return 6'b000011;
    return 6'd0;
  endfunction

  initial begin
    bit          exc_now [N];
    logic [5:0]  e_stall [N];
    logic [31:0] e_pc    [N];
    bit          e_flush;
    bit          s_rst;
    logic [31:0] s_exc, s_epc;
    @(posedge clk);
    forever begin
      @(negedge clk);
      s_rst = rst; s_exc = excepttype; s_epc = cp0_epc;
      for (int i = 0; i < N; i++) begin
        exc_now[i] = (rem[i] == 0) && (s_exc != 0);
        e_flush    = (rem[i] > 0) || exc_now[i];
        if (rem[i] > 0)      e_pc[i] = tgt[i];
        else if (exc_now[i]) e_pc[i] = (s_exc == 32'he) ? s_epc : 32'h20;
        else                 e_pc[i] = 32'd0;
        e_stall[i] = req_vec(e_flush, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        chk($sformatf("m_stall%0d", i), {26'd0, stall_v[i]}, {26'd0, e_stall[i]});
        chk($sformatf("m_flush%0d", i), {31'd0, flush_v[i]}, {31'd0, e_flush});
        chk($sformatf("m_newpc%0d", i), new_pc_v[i], e_pc[i]);
        chk($sformatf("m_tmo%0d", i), {31'd0, tmo_v[i]}, {31'd0, to[i]});
`ifdef PIPE_PERF_EN
        chk($sformatf("m_scyc%0d", i), scyc_v[i], m_scyc[i]);
        chk($sformatf("m_fev%0d", i), fev_v[i], m_fev[i]);
`endif
      end
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        if (s_rst) begin
          rem[i] = 0; tgt[i] = 0; run[i] = 0; to[i] = 0;
          m_scyc[i] = 0; m_fev[i] = 0;
        end else begin
          if (exc_now[i]) begin
            tgt[i] = e_pc[i];
            rem[i] = flen[i] - 1;
            m_fev[i]++;
          end else if (rem[i] > 0) begin
            rem[i]--;
          end
          if (e_stall[i] != 0) begin
            m_scyc[i]++;
            run[i] = (run[i] < TMO) ? run[i] + 1 : TMO;
          end else begin
            run[i] = 0;
          end
          if (run[i] == TMO) to[i] = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype = 0; cp0_epc = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick();
    rst = 0;
  endtask

  initial begin
    bit heavy;
    do_reset();
    #1;
    chk("rst_stall", {26'd0, stall_v[0]}, 32'd0);
    chk("rst_flush", {31'd0, flush_v[0]}, 32'd0);
    chk("rst_newpc", new_pc_v[0], 32'd0);
    chk("rst_tmo", {31'd0, tmo_v[0]}, 32'd0);

    // Priority: mem beats id, then id alone.
    stallreq_id = 1; stallreq_mem = 1; #1;
    chk("prio_mem", {26'd0, stall_v[0]}, 32'h1f);
    tick(); stallreq_mem = 0; #1;
    chk("prio_id", {26'd0, stall_v[0]}, 32'h07);

    // Single-cycle exception overrides stall (FLUSH_LEN=1).
    tick(); excepttype = 32'h1; #1;
    chk("exc1_flush", {31'd0, flush_v[0]}, 32'd1);
    chk("exc1_newpc", new_pc_v[0], 32'h20);
    chk("exc1_stall", {26'd0, stall_v[0]}, 32'd0);
    tick(); excepttype = 0; stallreq_id = 0; #1;
    chk("exc1_after_flush", {31'd0, flush_v[0]}, 32'd0);
    chk("exc1_after_newpc", new_pc_v[0], 32'd0);

    // ERET with FLUSH_LEN=3; second exception mid-flush ignored.
    do_reset();
    excepttype = 32'he; cp0_epc = 32'h1040; #1;
    chk("eret_c1", new_pc_v[1], 32'h1040);
    tick(); excepttype = 32'h1; cp0_epc = 0; #1;
    chk("eret_c2_flush", {31'd0, flush_v[1]}, 32'd1);
    chk("eret_c2", new_pc_v[1], 32'h1040);
    tick(); excepttype = 0; #1;
    chk("eret_c3", new_pc_v[1], 32'h1040);
    tick(); #1;
    chk("eret_c4_flush", {31'd0, flush_v[1]}, 32'd0);
    chk("eret_c4_newpc", new_pc_v[1], 32'd0);

    // Watchdog with TIMEOUT=8 on a held ex stall.
    do_reset();
    stallreq_ex = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("wd_k%0d", k), {31'd0, tmo_v[0]}, (k == 8) ? 32'd1 : 32'd0);
    end
    stallreq_ex = 0;
    tick();
    chk("wd_sticky", {31'd0, tmo_v[0]}, 32'd1);
    chk("wd_stall_unaltered", {26'd0, stall_v[0]}, 32'd0);

    // Reset in cycle 2 of a 4-cycle flush (timeout already set above).
    excepttype = 32'h3; tick();
    excepttype = 0; rst = 1; #1;
    chk("rstflush_c2", {31'd0, flush_v[2]}, 32'd1);
    tick(); rst = 0; #1;
    chk("rstflush_flush", {31'd0, flush_v[2]}, 32'd0);
    chk("rstflush_stall", {26'd0, stall_v[2]}, 32'd0);
    chk("rstflush_tmo", {31'd0, tmo_v[2]}, 32'd0);

`ifdef PIPE_PERF_EN
    do_reset();
    stallreq_if = 1;
    repeat (5) tick();
    stallreq_if = 0; excepttype = 32'h1;
    tick(); tick();
    excepttype = 0; #1;
    chk("perf_scyc", scyc_v[0], 32'd5);
    chk("perf_fev", fev_v[0], 32'd2);
`endif

    // Randomized traffic, checked every cycle by the model.
    do_reset();
    heavy = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 16 == 0) heavy = ($urandom_range(0, 3) == 0);
      rst          = ($urandom_range(0, 299) == 0);
      stallreq_if  = $urandom_range(0, 2) == 0;
      stallreq_id  = $urandom_range(0, 3) == 0;
      stallreq_ex  = heavy || ($urandom_range(0, 4) == 0);
      stallreq_mem = $urandom_range(0, 5) == 0;
      cp0_epc      = $urandom;
      if (!heavy && $urandom_range(0, 9) == 0)
        excepttype = ($urandom_range(0, 1) == 0) ? 32'he : ($urandom | 32'h1);
      else
        excepttype = 0;
    end
    tick();
    idle_inputs();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
